// File: rtl/cr_tlv_axi4s_tx_pkg.sv
// Shared types and constants for the TLV transmit packer.
package cr_tlv_axi4s_tx_pkg;

    localparam int unsigned TLV_DATA_W       = 64;
    localparam int unsigned TLV_USER_W       = 8;
    localparam int unsigned TLV_TYPE_W       = 8;
    localparam int unsigned TLV_LEN_W        = 16;
    localparam int unsigned TLV_SOT_BIT      = 0;
    localparam int unsigned TLV_EOT_BIT      = 1;
    localparam int unsigned TLV_HDR_TYPE_LSB = 0;
    localparam int unsigned TLV_HDR_LEN_LSB  = 8;

    typedef struct packed {
        logic [TLV_DATA_W-1:0] tdata;
        logic                  tlast;
        logic [TLV_USER_W-1:0] tuser;
    } tlv_tx_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLD  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/cr_tlv_tx_ofifo.sv
// Small synchronous FIFO of outbound TLV words; output is read straight from
// the storage registers, so nothing downstream sees a combinational path.
module cr_tlv_tx_ofifo
    import cr_tlv_axi4s_tx_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned AFULL_VAL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  tlv_tx_word_t din,
    input  logic         pop,
    output tlv_tx_word_t dout,
    output logic         full,
    output logic         afull,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    tlv_tx_word_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign free  = CW'(DEPTH) - count;
    assign afull = (32'(free) <= AFULL_VAL);

endmodule

// File: rtl/cr_tlv_axi4s_tx.sv
// TLV transmit packer: builds header words, tags sot/eot/tlast and feeds an
// AXI4-stream master through a registered output FIFO.
module cr_tlv_axi4s_tx
    import cr_tlv_axi4s_tx_pkg::*;
#(
    parameter int unsigned N_OB_ENTRIES   = 2,
    parameter int unsigned N_OB_AFULL_VAL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdr_vld,
    output logic        hdr_rdy,
    input  logic [7:0]  hdr_type,
    input  logic [15:0] hdr_len,
    input  logic        hdr_frm_end,
    input  logic        pld_vld,
    output logic        pld_rdy,
    input  logic [63:0] pld_data,
    output logic        axi4s_tvalid,
    input  logic        axi4s_tready,
    output logic [63:0] axi4s_tdata,
    output logic [7:0]  axi4s_tstrb,
    output logic        axi4s_tlast,
    output logic [7:0]  axi4s_tuser,
    output logic        ob_afull,
    output logic        tx_busy,
    output logic [31:0] tlv_cnt,
    output logic        tlv_tx_error
);

    tx_state_t              state;
    logic [TLV_LEN_W-1:0]   rem_cnt;
    logic                   frm_end_q;
    logic [TLV_LEN_W-1:0]   eff_len;
    logic                   hdr_eot;
    logic                   pld_eot;
    logic                   ob_full;
    logic                   ob_empty;
    logic                   ob_can_push;
    logic                   pop;
    logic                   push;
    logic                   hdr_acc;
    logic                   pld_acc;
    tlv_tx_word_t           push_word;
    tlv_tx_word_t           pop_word;

    assign pop         = axi4s_tvalid & axi4s_tready;
    assign ob_can_push = ~ob_full | pop;
    assign hdr_rdy     = (state == ST_IDLE) & ob_can_push;
    assign pld_rdy     = (state == ST_PLD) & ob_can_push;
    assign hdr_acc     = hdr_vld & hdr_rdy;
    assign pld_acc     = pld_vld & pld_rdy;
    assign push        = hdr_acc | pld_acc;

    // A zero length is emitted as a header-only TLV.
    assign eff_len = (hdr_len == '0) ? TLV_LEN_W'(1) : hdr_len;
    assign hdr_eot = (eff_len == TLV_LEN_W'(1));
    assign pld_eot = (rem_cnt == TLV_LEN_W'(1));

    // Word presented to the FIFO; only consumed when push is high.
    always_comb begin
        push_word = '0;
        if (state == ST_IDLE) begin
            push_word.tdata[TLV_HDR_TYPE_LSB +: TLV_TYPE_W] = hdr_type;
            push_word.tdata[TLV_HDR_LEN_LSB +: TLV_LEN_W]   = eff_len;
            push_word.tuser[TLV_SOT_BIT]                    = 1'b1;
            push_word.tuser[TLV_EOT_BIT]                    = hdr_eot;
            push_word.tlast                                 = hdr_eot & hdr_frm_end;
        end else begin
            push_word.tdata              = pld_data;
            push_word.tuser[TLV_EOT_BIT] = pld_eot;
            push_word.tlast              = pld_eot & frm_end_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rem_cnt      <= '0;
            frm_end_q    <= 1'b0;
            tlv_cnt      <= '0;
            tlv_tx_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hdr_acc) begin
                        if (hdr_len == '0) begin
                            tlv_tx_error <= 1'b1;
                        end
                        if (hdr_eot) begin
                            tlv_cnt <= tlv_cnt + 32'd1;
                        end else begin
                            rem_cnt   <= eff_len - TLV_LEN_W'(1);
                            frm_end_q <= hdr_frm_end;
                            state     <= ST_PLD;
                        end
                    end
                end
                ST_PLD: begin
                    if (pld_acc) begin
                        rem_cnt <= rem_cnt - TLV_LEN_W'(1);
                        if (pld_eot) begin
                            tlv_cnt <= tlv_cnt + 32'd1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cr_tlv_tx_ofifo #(
        .DEPTH     (N_OB_ENTRIES),
        .AFULL_VAL (N_OB_AFULL_VAL)
    ) u_ofifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (pop_word),
        .full  (ob_full),
        .afull (ob_afull),
        .empty (ob_empty)
    );

    assign axi4s_tvalid = ~ob_empty;
    assign axi4s_tdata  = pop_word.tdata;
    assign axi4s_tlast  = pop_word.tlast;
    assign axi4s_tuser  = pop_word.tuser;
    assign axi4s_tstrb  = 8'hFF;
    assign tx_busy      = (state != ST_IDLE) | ~ob_empty;

endmodule
